// File: rtl/fixed_point_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared definitions for the fixed-point FIR/MAC datapath (multiplier, adder).
//   fxp_state_t     : IDLE/CALC/FINAL sequencing state for iterative units.
//   fxp_max(width)  : largest value of a signed two's complement number of
//                     'width' bits.
//   fxp_min(width)  : smallest value of a signed two's complement number of
//                     'width' bits.
// Both functions return 64-bit signed values.
// Configuration: none (FXMUL_ROUND_EN is consumed by fxp_round_sat).
// -----------------------------------------------------------------------------
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } fxp_state_t;

    function automatic logic signed [63:0] fxp_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fxp_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// -----------------------------------------------------------------------------
// fxp_round_sat
// Combinational rescale of a signed IN_W-bit value by FBITS fractional bits.
// It rounds optionally, then saturates the result to a signed OUT_W-bit value.
// Configuration macro: FXMUL_ROUND_EN.
//   When FXMUL_ROUND_EN is defined, the unit rounds half-up: it adds
//   2^(FBITS-1) before the shift, and skips the addition when FBITS = 0.
//   When FXMUL_ROUND_EN is undefined, it truncates. The arithmetic shift alone
//   rounds toward -inf.
// Saturation is checked after rounding.
// Ports:
//   i_val  in   IN_W   signed value to rescale
//   o_val  out  OUT_W  rescaled, saturated value
//   o_ovf  out  1      o_val was clamped to a saturation bound
// -----------------------------------------------------------------------------
module fxp_round_sat
    import fixed_point_pkg::*;
#(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned FBITS = 4
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_ovf
);

    // Bounds are widened to IN_W so the compare happens at full precision.
    localparam logic signed [IN_W-1:0] MaxV = IN_W'(fxp_max(OUT_W));
    localparam logic signed [IN_W-1:0] MinV = IN_W'(fxp_min(OUT_W));

    logic signed [IN_W-1:0] w_rounded;
    logic signed [IN_W-1:0] w_shifted;

`ifdef FXMUL_ROUND_EN
    localparam int unsigned HalfPos = (FBITS > 0) ? FBITS - 1 : 0;
    localparam logic signed [IN_W-1:0] Half = (FBITS > 0) ? (IN_W'(1) <<< HalfPos) : '0;

    assign w_rounded = i_val + Half;
`else
    assign w_rounded = i_val;
`endif

    assign w_shifted = w_rounded >>> FBITS;

    always_comb begin
        o_ovf = 1'b0;
        o_val = w_shifted[OUT_W-1:0];
        if (w_shifted > MaxV) begin
            o_val = MaxV[OUT_W-1:0];
            o_ovf = 1'b1;
        end else if (w_shifted < MinV) begin
            o_val = MinV[OUT_W-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_multiplier.sv
// -----------------------------------------------------------------------------
// fixed_point_multiplier
// Sequential signed fixed-point multiplier for the FIR tap/MAC datapath.
// Inputs and outputs use the Q(WIDTH-FBITS-1).FBITS format.
// Sequence:
//   1. A shift-add over the operand magnitudes takes WIDTH cycles.
//   2. One FINAL cycle then applies the sign.
//   3. fxp_round_sat rescales, rounds and saturates the product.
// The start/busy/done/valid handshake matches the saturating adder.
// Configuration macro: FXMUL_ROUND_EN. When defined, the rescale rounds
// half-up; when undefined, it truncates. The switch lives in fxp_round_sat.
// Ports:
//   i_clk       in   1      clock, rising edge
//   i_rst_n     in   1      synchronous active-low reset
//   i_start     in   1      request, sampled only in IDLE
//   i_operandA  in   WIDTH  signed multiplicand
//   i_operandB  in   WIDTH  signed multiplier
//   o_busy      out  1      product in flight (CALC or FINAL)
//   o_done      out  1      one-cycle pulse when o_val updates
//   o_valid     out  1      o_val holds a completed result
//   o_ovf       out  1      last result was saturated
//   o_val       out  WIDTH  signed product
// -----------------------------------------------------------------------------
module fixed_point_multiplier
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FBITS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_operandA,
    input  logic [WIDTH-1:0] i_operandB,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_valid,
    output logic             o_ovf,
    output logic [WIDTH-1:0] o_val
);

    localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ProdW = 2 * WIDTH + 1;

    fxp_state_t r_state;
    fxp_state_t w_state_next;

    logic [CntW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mult;
    logic               r_sign;
    logic               r_done;
    logic               r_valid;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_val;

    logic                    w_accept;
    logic                    w_last_bit;
    logic signed [ProdW-1:0] w_prod;
    logic signed [WIDTH-1:0] w_sat_val;
    logic                    w_sat_ovf;

    // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1), so -2^(WIDTH-1) is exact.
    function automatic logic [WIDTH-1:0] fxp_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_last_bit = (r_cnt == CntW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    if (w_last_bit) w_state_next = FINAL;
            FINAL:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mult  <= '0;
            r_sign  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= {{WIDTH{1'b0}}, fxp_abs(i_operandA)};
                        r_mult  <= fxp_abs(i_operandB);
                        r_acc   <= '0;
                        r_sign  <= i_operandA[WIDTH-1] ^ i_operandB[WIDTH-1];
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                CALC: begin
                    if (r_mult[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mult  <= r_mult >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                FINAL: begin
                    r_val   <= w_sat_val;
                    r_ovf   <= w_sat_ovf;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The magnitude is at most 2^(2*WIDTH-2), so negation in ProdW bits cannot wrap.
    assign w_prod = r_sign ? -$signed({1'b0, r_acc}) : $signed({1'b0, r_acc});

    fxp_round_sat #(
        .IN_W  (ProdW),
        .OUT_W (WIDTH),
        .FBITS (FBITS)
    ) u_round_sat (
        .i_val (w_prod),
        .o_val (w_sat_val),
        .o_ovf (w_sat_ovf)
    );

    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;
    assign o_val   = r_val;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_multiplier
// Scoreboard bench for fixed_point_multiplier, with WIDTH=8 and FBITS=4 (Q3.4).
// Expected results are queued when a start is driven. A monitor pops one
// result and compares it on every o_done. Honours FXMUL_ROUND_EN when defined.
// -----------------------------------------------------------------------------
module tb_fixed_point_multiplier;

    localparam int unsigned W = 8;
    localparam int unsigned F = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy;
    logic         done;
    logic         valid;
    logic         ovf;
    logic [W-1:0] val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done = 0;
    bit chk_period = 1'b0;

    // Each entry is {ovf, val}.
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    fixed_point_multiplier #(
        .WIDTH (W),
        .FBITS (F)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_operandA (opa),
        .i_operandB (opb),
        .o_busy     (busy),
        .o_done     (done),
        .o_valid    (valid),
        .o_ovf      (ovf),
        .o_val      (val)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, then round, shift and saturate.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint p;
        longint maxv;
        longint minv;
        logic   ov;
        logic [W-1:0] v;
        p = longint'($signed(ma)) * longint'($signed(mb));
`ifdef FXMUL_ROUND_EN
        if (F > 0) p = p + (longint'(1) <<< (F - 1));
`endif
        p    = p >>> F;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        ov   = 1'b0;
        if (p > maxv) begin
            p  = maxv;
            ov = 1'b1;
        end else if (p < minv) begin
            p  = minv;
            ov = 1'b1;
        end
        v = p[W-1:0];
        return {ov, v};
    endfunction

    // Monitor: pops one expected result per o_done.
    always begin
        logic [W:0] e;
        @(posedge clk);
        cyc++;
        #1;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("done_without_request", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("val", val, e[W-1:0]);
                check_eq("ovf", ovf, e[W]);
                check_eq("valid_at_done", valid, 1);
                check_eq("busy_at_done", busy, 0);
            end
            if (chk_period && last_done != 0) check_eq("done_period", cyc - last_done, W + 2);
            last_done = cyc;
        end
    end

    // One transaction from IDLE. Latency counts edges from the accepting edge
    // to the edge that raises o_done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W:0] e);
        int n;
        @(negedge clk);
        opa   = ta;
        opb   = tb;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n = 1;
        check_eq("busy_after_accept", busy, 1);
        check_eq("valid_clr_on_accept", valid, 0);
        @(negedge clk);
        start = 1'b0;
        opa   = ~ta;
        opb   = ~tb;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, W + 2);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];
        int d0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_val", val, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h18, 8'h20, 9'h030);
        run_op(8'hE8, 8'h20, 9'h0D0);
        run_op(8'h80, 8'h10, 9'h080);
        run_op(8'h7F, 8'h7F, 9'h17F);
        run_op(8'h80, 8'h80, 9'h17F);
        run_op(8'h80, 8'h7F, 9'h180);

        // Result must hold while idle.
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_valid", valid, 1);
        check_eq("hold_val", val, 8'h80);
        check_eq("hold_ovf", ovf, 1);

`ifdef FXMUL_ROUND_EN
        run_op(8'h01, 8'h08, 9'h001);
        run_op(8'hFF, 8'h08, 9'h000);
`else
        run_op(8'h01, 8'h08, 9'h000);
        run_op(8'hFF, 8'h08, 9'h0FF);
`endif
        run_op(8'h00, 8'h55, 9'h000);

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, model(ra, rb));
        end

        // Start held for 30 cycles while the operands change on every cycle.
        // Accepts must fall on edges 1, 11 and 21.
        pa[0] = 8'h24; pb[0] = 8'hD3;
        pa[1] = 8'h9C; pb[1] = 8'h9C;
        pa[2] = 8'h7F; pb[2] = 8'h7F;
        chk_period = 1'b1;
        last_done  = 0;
        @(negedge clk);
        start = 1'b1;
        opa   = pa[0];
        opb   = pb[0];
        exp_q.push_back(model(pa[0], pb[0]));
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 10 || k == 20) check_eq("valid_before_accept", valid, 1);
            if (k == 11 || k == 21) begin
                check_eq("valid_drop_on_accept", valid, 0);
                check_eq("busy_on_accept", busy, 1);
            end
            @(negedge clk);
            if (k == 30) start = 1'b0;
            if (k == 10 || k == 20) begin
                opa = pa[k/10];
                opb = pb[k/10];
                exp_q.push_back(model(pa[k/10], pb[k/10]));
            end else begin
                opa = W'($urandom);
                opb = W'($urandom);
            end
        end
        chk_period = 1'b0;
        check_eq("hs_done_count", exp_q.size(), 0);

        // Reset in CALC cycle 3 aborts the product.
        @(negedge clk);
        opa   = 8'h18;
        opb   = 8'h20;
        start = 1'b1;
        exp_q.push_back(9'h030);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_valid", valid, 0);
        check_eq("abort_ovf", ovf, 0);
        check_eq("abort_val", val, 0);
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", done_cnt - d0, 0);

        run_op(8'h18, 8'h20, 9'h030);
        run_op(8'hE8, 8'h18, model(8'hE8, 8'h18));

        repeat (3) @(posedge clk);
        #1;
        check_eq("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
